// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the two writeback sources, the decode claim, and the register-file write port.
// Both A and B use strict valid/ready: a beat transfers only on a cycle where valid and ready are both high; the source holds its beat until then.
interface regfile_write_arbiter_if #(
   parameter int DATA_W   = 24,
   parameter int IDX_W    = 5,
   parameter int NUM_REGS = 32,
   parameter int CNT_W    = 8
);
   logic                a_valid;
   logic [IDX_W-1:0]    a_index;
   logic [DATA_W-1:0]   a_data;
   logic                a_ready;
   logic                b_valid;
   logic [IDX_W-1:0]    b_index;
   logic [DATA_W-1:0]   b_data;
   logic                b_ready;
   logic                claim_valid;
   logic [IDX_W-1:0]    claim_index;
   logic                rf_write_enable;
   logic [IDX_W-1:0]    rf_write_index;
   logic [DATA_W-1:0]   rf_write_data;
   logic [NUM_REGS-1:0] pending;
   logic [CNT_W-1:0]    conflict_count;

   modport master (
      output a_valid, a_index, a_data, b_valid, b_index, b_data, claim_valid, claim_index,
      input  a_ready, b_ready, rf_write_enable, rf_write_index, rf_write_data, pending,
             conflict_count
   );

   modport slave (
      input  a_valid, a_index, a_data, b_valid, b_index, b_data, claim_valid, claim_index,
      output a_ready, b_ready, rf_write_enable, rf_write_index, rf_write_data, pending,
             conflict_count
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU (A) and load (B)
// writeback, with a registered write port and a per-register pending-write scoreboard.
module regfile_write_arbiter #(
   parameter int DATA_W    = 24,
   parameter int IDX_W     = 5,
   parameter int NUM_REGS  = 32,
   parameter int LONG_BASE = 28,
   parameter int CNT_W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   regfile_write_arbiter_if.slave   bus,
   output logic                     dbg_ptr_o
);

   typedef enum logic {
      PTR_A = 1'b0,
      PTR_B = 1'b1
   } ptr_e;

   localparam logic [IDX_W-1:0] LONG_IDX = IDX_W'(LONG_BASE);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

   ptr_e                ptr_q, ptr_d;
   logic                a_ready, b_ready;
   logic                a_fire, b_fire, any_fire;
   logic [IDX_W-1:0]    win_idx;
   logic [DATA_W-1:0]   win_data, fmt_data;
   logic                we_q, we_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // Grant and pointer: under contention the pointer picks, otherwise the lone requester wins.
   always_comb begin
      a_ready = 1'b0;
      b_ready = 1'b0;
      if (rst_n) begin
         if (bus.a_valid && bus.b_valid) begin
            a_ready = (ptr_q == PTR_A);
            b_ready = (ptr_q == PTR_B);
         end else begin
            a_ready = bus.a_valid;
            b_ready = bus.b_valid;
         end
      end
      a_fire   = bus.a_valid && a_ready;
      b_fire   = bus.b_valid && b_ready;
      any_fire = a_fire || b_fire;
      ptr_d    = ptr_q;
      if (a_fire) begin
         ptr_d = PTR_B;
      end else if (b_fire) begin
         ptr_d = PTR_A;
      end
   end

   // Short registers only carry 16 significant bits; the upper byte is forced to zero.
   always_comb begin
      win_idx  = a_fire ? bus.a_index : bus.b_index;
      win_data = a_fire ? bus.a_data  : bus.b_data;
      fmt_data = win_data;
      if (win_idx < LONG_IDX) begin
         fmt_data = {{(DATA_W-16){1'b0}}, win_data[15:0]};
      end
      we_d   = any_fire;
      idx_d  = any_fire ? win_idx  : idx_q;
      data_d = any_fire ? fmt_data : data_q;
   end

   // The clear applies first so a coincident claim of the same index keeps it pending.
   always_comb begin
      pending_d = pending_q;
      if (we_q) begin
         pending_d[idx_q] = 1'b0;
      end
      if (bus.claim_valid) begin
         pending_d[bus.claim_index] = 1'b1;
      end
      cnt_d = cnt_q;
      if (bus.a_valid && bus.b_valid && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q     <= PTR_A;
         we_q      <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         pending_q <= '0;
         cnt_q     <= '0;
      end else begin
         ptr_q     <= ptr_d;
         we_q      <= we_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         pending_q <= pending_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.a_ready         = a_ready;
   assign bus.b_ready         = b_ready;
   assign bus.rf_write_enable = we_q;
   assign bus.rf_write_index  = idx_q;
   assign bus.rf_write_data   = data_q;
   assign bus.pending         = pending_q;
   assign bus.conflict_count  = cnt_q;
   assign dbg_ptr_o           = ptr_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: reset, width rule, round-robin contention,
// scoreboard set/clear ordering, mid-operation reset and counter saturation.
module tb_regfile_write_arbiter;

   logic clk;
   logic rst_n;
   logic dbg_ptr;
   int   checks;
   int   errors;

   regfile_write_arbiter_if #(.DATA_W(24), .IDX_W(5), .NUM_REGS(32), .CNT_W(8)) bus ();

   regfile_write_arbiter #(
      .DATA_W(24), .IDX_W(5), .NUM_REGS(32), .LONG_BASE(28), .CNT_W(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_ptr_o (dbg_ptr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_a(input logic v, input logic [4:0] idx, input logic [23:0] d);
      bus.a_valid = v;
      bus.a_index = idx;
      bus.a_data  = d;
   endtask

   task automatic drive_b(input logic v, input logic [4:0] idx, input logic [23:0] d);
      bus.b_valid = v;
      bus.b_index = idx;
      bus.b_data  = d;
   endtask

   task automatic drive_claim(input logic v, input logic [4:0] idx);
      bus.claim_valid = v;
      bus.claim_index = idx;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      drive_a(1'b0, 5'd0, 24'h0);
      drive_b(1'b0, 5'd0, 24'h0);
      drive_claim(1'b0, 5'd0);

      // reset with A requesting
      tick();
      drive_a(1'b1, 5'd1, 24'h000001);
      #1;
      chk("rst_a_ready", 64'(bus.a_ready), 64'd0);
      tick();
      chk("rst_we", 64'(bus.rf_write_enable), 64'd0);
      chk("rst_idx", 64'(bus.rf_write_index), 64'd0);
      chk("rst_data", 64'(bus.rf_write_data), 64'd0);
      chk("rst_pending", 64'(bus.pending), 64'd0);
      chk("rst_count", 64'(bus.conflict_count), 64'd0);
      chk("rst_ptr", 64'(dbg_ptr), 64'd0);
      rst_n = 1'b1;
      drive_a(1'b0, 5'd0, 24'h0);

      // single A write to a short register
      tick();
      drive_a(1'b1, 5'd5, 24'hABCDEF);
      #1;
      chk("singleA_a_ready", 64'(bus.a_ready), 64'd1);
      chk("singleA_b_ready", 64'(bus.b_ready), 64'd0);
      tick();
      drive_a(1'b0, 5'd0, 24'h0);
      chk("singleA_we", 64'(bus.rf_write_enable), 64'd1);
      chk("singleA_idx", 64'(bus.rf_write_index), 64'd5);
      chk("singleA_data", 64'(bus.rf_write_data), 64'h00CDEF);
      chk("singleA_ptr", 64'(dbg_ptr), 64'd1);
      tick();
      chk("idle_we", 64'(bus.rf_write_enable), 64'd0);
      chk("idle_idx_hold", 64'(bus.rf_write_index), 64'd5);
      chk("idle_data_hold", 64'(bus.rf_write_data), 64'h00CDEF);

      // B write to a long register; register 27 is the last short one
      drive_b(1'b1, 5'd30, 24'h123456);
      #1;
      chk("longB_b_ready", 64'(bus.b_ready), 64'd1);
      tick();
      drive_b(1'b1, 5'd27, 24'h654321);
      chk("longB_data", 64'(bus.rf_write_data), 64'h123456);
      chk("longB_idx", 64'(bus.rf_write_index), 64'd30);
      chk("longB_ptr", 64'(dbg_ptr), 64'd0);
      tick();
      drive_b(1'b1, 5'd28, 24'h654321);
      chk("short27_data", 64'(bus.rf_write_data), 64'h004321);
      tick();
      drive_b(1'b0, 5'd0, 24'h0);
      chk("long28_data", 64'(bus.rf_write_data), 64'h654321);
      tick();

      // contention: pointer is back at A, expect grants A, B, A
      drive_a(1'b1, 5'd3, 24'hFF0111);
      drive_b(1'b1, 5'd4, 24'hFF0222);
      #1;
      chk("cont1_a_ready", 64'(bus.a_ready), 64'd1);
      chk("cont1_b_ready", 64'(bus.b_ready), 64'd0);
      tick();
      chk("cont1_idx", 64'(bus.rf_write_index), 64'd3);
      chk("cont1_data", 64'(bus.rf_write_data), 64'h000111);
      chk("cont2_a_ready", 64'(bus.a_ready), 64'd0);
      chk("cont2_b_ready", 64'(bus.b_ready), 64'd1);
      tick();
      chk("cont2_idx", 64'(bus.rf_write_index), 64'd4);
      chk("cont2_data", 64'(bus.rf_write_data), 64'h000222);
      chk("cont3_a_ready", 64'(bus.a_ready), 64'd1);
      tick();
      drive_a(1'b0, 5'd0, 24'h0);
      drive_b(1'b0, 5'd0, 24'h0);
      chk("cont3_we", 64'(bus.rf_write_enable), 64'd1);
      chk("cont3_idx", 64'(bus.rf_write_index), 64'd3);
      chk("cont_count", 64'(bus.conflict_count), 64'd3);
      chk("cont_pending", 64'(bus.pending), 64'd0);

      // scoreboard: claim 7, write 7 lands, then clears
      drive_claim(1'b1, 5'd7);
      tick();
      drive_claim(1'b0, 5'd0);
      chk("sb_claim", 64'(bus.pending), 64'h80);
      drive_a(1'b1, 5'd7, 24'h000077);
      tick();
      drive_a(1'b0, 5'd0, 24'h0);
      chk("sb_landing_we", 64'(bus.rf_write_enable), 64'd1);
      chk("sb_landing_pend", 64'(bus.pending), 64'h80);
      tick();
      chk("sb_cleared", 64'(bus.pending), 64'h0);

      // claim coincident with the landing write of the same index: set wins
      drive_claim(1'b1, 5'd7);
      drive_a(1'b1, 5'd7, 24'h000078);
      tick();
      drive_a(1'b0, 5'd0, 24'h0);
      drive_claim(1'b1, 5'd7);
      chk("sb_re_claim", 64'(bus.pending), 64'h80);
      tick();
      drive_claim(1'b0, 5'd0);
      chk("sb_set_wins", 64'(bus.pending), 64'h80);
      tick();
      chk("sb_set_holds", 64'(bus.pending), 64'h80);

      // claim of a different index while 7 lands
      drive_a(1'b1, 5'd7, 24'h000079);
      tick();
      drive_a(1'b0, 5'd0, 24'h0);
      drive_claim(1'b1, 5'd9);
      tick();
      drive_claim(1'b0, 5'd0);
      chk("sb_swap", 64'(bus.pending), 64'h200);

      // reset mid-operation: pointer at B, claim 12 pending, A requesting
      drive_claim(1'b1, 5'd12);
      drive_a(1'b1, 5'd2, 24'h000222);
      drive_b(1'b1, 5'd6, 24'h000666);
      tick();
      drive_claim(1'b0, 5'd0);
      chk("mid_pre_pending", 64'(bus.pending), 64'h1200);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_a_ready", 64'(bus.a_ready), 64'd0);
      chk("mid_rst_b_ready", 64'(bus.b_ready), 64'd0);
      tick();
      rst_n = 1'b1;
      drive_a(1'b0, 5'd0, 24'h0);
      drive_b(1'b0, 5'd0, 24'h0);
      chk("mid_we", 64'(bus.rf_write_enable), 64'd0);
      chk("mid_pending", 64'(bus.pending), 64'h0);
      chk("mid_count", 64'(bus.conflict_count), 64'd0);
      chk("mid_ptr", 64'(dbg_ptr), 64'd0);

      // saturation of the conflict counter
      drive_a(1'b1, 5'd10, 24'h0);
      drive_b(1'b1, 5'd11, 24'h0);
      for (int i = 0; i < 254; i++) tick();
      chk("sat_254", 64'(bus.conflict_count), 64'd254);
      tick();
      chk("sat_255", 64'(bus.conflict_count), 64'd255);
      for (int i = 0; i < 45; i++) tick();
      chk("sat_300", 64'(bus.conflict_count), 64'd255);
      drive_a(1'b0, 5'd0, 24'h0);
      drive_b(1'b0, 5'd0, 24'h0);
      tick();
      tick();
      chk("sat_hold", 64'(bus.conflict_count), 64'd255);
      chk("sat_idle_we", 64'(bus.rf_write_enable), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
